// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: full-throughput AXI4-Stream register slice (2-entry skid buffer).
// Every output is driven from a flop, so m_axis_tready never reaches s_axis_tready
// within a cycle. The block also counts output beats and packets for status readout.
module axis_skid_buffer #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                         clk_i,
    input  logic                         arst_n_i,
    input  logic                         s_axis_tvalid,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic                         m_axis_tvalid,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    input  logic                         cnt_clr_i,
    output logic [CNT_WIDTH-1:0]         beat_cnt_o,
    output logic [CNT_WIDTH-1:0]         pkt_cnt_o
);

    localparam int SW = AXIS_DATA_WIDTH / 8;

    // Encoding is {main_v, skid_v}; the (0,1) combination is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t                       state_q, state_d;
    logic                         ready_q;
    logic                         in_hs, out_hs;
    logic                         load_main_s, load_main_skid, load_skid;

    logic [AXIS_DATA_WIDTH-1:0]   main_data_q, skid_data_q;
    logic [SW-1:0]                main_strb_q, skid_strb_q;
    logic                         main_last_q, skid_last_q;
    logic [CNT_WIDTH-1:0]         beat_cnt_q, pkt_cnt_q;

    assign in_hs  = s_axis_tvalid & ready_q;
    assign out_hs = state_q[1] & m_axis_tready;

    // State register plus the registered upstream ready (low while in reset).
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_FULL);
        end
    end

    // Next-state and load-enable decode from the two handshakes.
    // NOTE: every output gets a default first so no latch is inferred on unlisted paths.
    always_comb begin
        state_d        = state_q;
        load_main_s    = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_hs) begin
                    load_main_s = 1'b1;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_hs && out_hs) begin
                    load_main_s = 1'b1;
                end else if (in_hs) begin
                    load_skid = 1'b1;
                    state_d   = ST_FULL;
                end else if (out_hs) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_hs) begin
                    load_main_skid = 1'b1;
                    state_d        = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Payload registers; data, strobes and last always move together.
    // NOTE: payload flops are reset too, so m_axis_* reads as zero during and after reset.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            main_data_q <= '0;
            main_strb_q <= '0;
            main_last_q <= 1'b0;
            skid_data_q <= '0;
            skid_strb_q <= '0;
            skid_last_q <= 1'b0;
        end else begin
            if (load_main_s) begin
                main_data_q <= s_axis_tdata;
                main_strb_q <= s_axis_tstrb;
                main_last_q <= s_axis_tlast;
            end else if (load_main_skid) begin
                main_data_q <= skid_data_q;
                main_strb_q <= skid_strb_q;
                main_last_q <= skid_last_q;
            end
            if (load_skid) begin
                skid_data_q <= s_axis_tdata;
                skid_strb_q <= s_axis_tstrb;
                skid_last_q <= s_axis_tlast;
            end
        end
    end

    // Beat and packet counters; they wrap, and a clear beats a same-cycle handshake.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            beat_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else if (cnt_clr_i) begin
            beat_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else if (out_hs) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (main_last_q) begin
                pkt_cnt_q <= pkt_cnt_q + 1'b1;
            end
        end
    end

    assign s_axis_tready = ready_q;
    assign m_axis_tvalid = state_q[1];
    assign m_axis_tdata  = main_data_q;
    assign m_axis_tstrb  = main_strb_q;
    assign m_axis_tlast  = main_last_q;
    assign beat_cnt_o    = beat_cnt_q;
    assign pkt_cnt_o     = pkt_cnt_q;

endmodule
